// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: datapath widths,
// instruction field positions and FSM state encodings.
package alu_pkg;

  localparam int DATA_W    = 8;
  localparam int FLAG_W    = 8;
  localparam int OPC_W     = 3;
  localparam int REG_IDX_W = 3;
  localparam int INSTR_W   = 16;

  // Instruction word layout
  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 13;
  localparam int RD_HI    = 12;
  localparam int RD_LO    = 10;
  localparam int RS1_HI   = 9;
  localparam int RS1_LO   = 7;
  localparam int RS2_HI   = 6;
  localparam int RS2_LO   = 4;
  localparam int NOWB_BIT = 3;

  // Sequencer states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_WB     = 2'd3;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU issue controller: one synchronous write port,
// three combinational read ports (two operands plus debug), zero on reset.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W   = alu_pkg::DATA_W,
  parameter int NUM_REGS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_we,
  input  logic [REG_IDX_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [REG_IDX_W-1:0] i_raddr1,
  input  logic [REG_IDX_W-1:0] i_raddr2,
  input  logic [REG_IDX_W-1:0] i_raddr3,
  output logic [DATA_W-1:0]    o_rdata1,
  output logic [DATA_W-1:0]    o_rdata2,
  output logic [DATA_W-1:0]    o_rdata3
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  // Storage update: clear everything on reset, otherwise a single write per cycle
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];
  assign o_rdata3 = r_mem[i_raddr3];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue/writeback sequencer: accepts instruction words, reads operands
// from the local register file, holds them on the ALU for ALU_LAT cycles,
// captures the result and flags, then writes the result back to rd.
// Optional build macro CMP_NOWB_EN: instr[3]=1 turns the instruction into a
// compare/test that reports its result without writing rd.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W   = alu_pkg::DATA_W,
  parameter int NUM_REGS = 8,
  parameter int ALU_LAT  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_instr_valid,
  output logic                 o_instr_ready,
  input  logic [INSTR_W-1:0]   i_instr,
  input  logic                 i_ld_en,
  input  logic [REG_IDX_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0]    i_ld_data,
  output logic [DATA_W-1:0]    o_alu_in1,
  output logic [DATA_W-1:0]    o_alu_in2,
  output logic [OPC_W-1:0]     o_alu_opcode,
  input  logic [DATA_W-1:0]    i_alu_data,
  input  logic [FLAG_W-1:0]    i_alu_flags,
  output logic                 o_result_valid,
  output logic [DATA_W-1:0]    o_result_data,
  output logic [FLAG_W-1:0]    o_result_flags,
  input  logic [REG_IDX_W-1:0] i_dbg_addr,
  output logic [DATA_W-1:0]    o_dbg_data
);

  logic [1:0]           r_state;
  logic [OPC_W-1:0]     r_opc;
  logic [REG_IDX_W-1:0] r_rd;
  logic [REG_IDX_W-1:0] r_rs1;
  logic [REG_IDX_W-1:0] r_rs2;
  logic [3:0]           r_cnt;
  logic [DATA_W-1:0]    r_alu_in1;
  logic [DATA_W-1:0]    r_alu_in2;
  logic [OPC_W-1:0]     r_alu_opc;
  logic [DATA_W-1:0]    r_res_data;
  logic [FLAG_W-1:0]    r_res_flags;

  logic                 w_idle;
  logic                 w_accept;
  logic                 w_ld_fire;
  logic                 w_wb_fire;
  logic                 w_rf_we;
  logic [REG_IDX_W-1:0] w_rf_waddr;
  logic [DATA_W-1:0]    w_rf_wdata;
  logic [DATA_W-1:0]    w_rs1_data;
  logic [DATA_W-1:0]    w_rs2_data;

  assign w_idle        = (r_state == ST_IDLE);
  assign o_instr_ready = w_idle && !i_ld_en;
  assign w_accept      = i_instr_valid && o_instr_ready;
  assign w_ld_fire     = w_idle && i_ld_en;

`ifdef CMP_NOWB_EN
  logic r_nowb;
  logic w_unused_instr;
  assign w_unused_instr = ^i_instr[2:0];
  assign w_wb_fire      = (r_state == ST_WB) && !r_nowb;

  // Remember whether the accepted instruction is a compare-only (no writeback)
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_nowb <= 1'b0;
    end else if (w_accept) begin
      r_nowb <= i_instr[NOWB_BIT];
    end
  end
`else
  logic w_unused_instr;
  assign w_unused_instr = ^i_instr[3:0];
  assign w_wb_fire      = (r_state == ST_WB);
`endif

  // Preload and writeback never collide: preload only fires in IDLE
  assign w_rf_we    = w_ld_fire || w_wb_fire;
  assign w_rf_waddr = w_ld_fire ? i_ld_addr : r_rd;
  assign w_rf_wdata = w_ld_fire ? i_ld_data : r_res_data;

  alu_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_we     (w_rf_we),
    .i_waddr  (w_rf_waddr),
    .i_wdata  (w_rf_wdata),
    .i_raddr1 (r_rs1),
    .i_raddr2 (r_rs2),
    .i_raddr3 (i_dbg_addr),
    .o_rdata1 (w_rs1_data),
    .o_rdata2 (w_rs2_data),
    .o_rdata3 (o_dbg_data)
  );

  // Sequencer: latch instruction, drive ALU, wait ALU_LAT cycles, capture, write back
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_opc       <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_cnt       <= '0;
      r_alu_in1   <= '0;
      r_alu_in2   <= '0;
      r_alu_opc   <= '0;
      r_res_data  <= '0;
      r_res_flags <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_opc   <= i_instr[OPC_HI:OPC_LO];
            r_rd    <= i_instr[RD_HI:RD_LO];
            r_rs1   <= i_instr[RS1_HI:RS1_LO];
            r_rs2   <= i_instr[RS2_HI:RS2_LO];
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_alu_in1 <= w_rs1_data;
          r_alu_in2 <= w_rs2_data;
          r_alu_opc <= r_opc;
          r_cnt     <= 4'(ALU_LAT);
          r_state   <= ST_EXEC;
        end
        ST_EXEC: begin
          if (r_cnt == 4'd1) begin
            r_res_data  <= i_alu_data;
            r_res_flags <= i_alu_flags;
            r_state     <= ST_WB;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_WB: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_alu_in1      = r_alu_in1;
  assign o_alu_in2      = r_alu_in2;
  assign o_alu_opcode   = r_alu_opc;
  assign o_result_valid = (r_state == ST_WB);
  assign o_result_data  = r_res_data;
  assign o_result_flags = r_res_flags;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl. A cycle-level reference model
// (busy countdown plus a register array) predicts every output; accepted
// instructions push their expected result into a queue that a separate
// negedge monitor pops whenever the DUT pulses result_valid.
// Honours CMP_NOWB_EN the same way the design does.
module tb_alu_issue_ctrl;

  localparam int ALU_LAT = 3;

  logic        clk = 1'b0;
  logic        rstN;
  logic        instrValid;
  logic        instrReady;
  logic [15:0] instr;
  logic        ldEn;
  logic [2:0]  ldAddr;
  logic [7:0]  ldData;
  logic [7:0]  aluIn1;
  logic [7:0]  aluIn2;
  logic [2:0]  aluOpcode;
  logic [7:0]  aluData;
  logic [7:0]  aluFlags;
  logic        resultValid;
  logic [7:0]  resultData;
  logic [7:0]  resultFlags;
  logic [2:0]  dbgAddr;
  logic [7:0]  dbgData;

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .DATA_W   (8),
    .NUM_REGS (8),
    .ALU_LAT  (ALU_LAT)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_instr_valid  (instrValid),
    .o_instr_ready  (instrReady),
    .i_instr        (instr),
    .i_ld_en        (ldEn),
    .i_ld_addr      (ldAddr),
    .i_ld_data      (ldData),
    .o_alu_in1      (aluIn1),
    .o_alu_in2      (aluIn2),
    .o_alu_opcode   (aluOpcode),
    .i_alu_data     (aluData),
    .i_alu_flags    (aluFlags),
    .o_result_valid (resultValid),
    .o_result_data  (resultData),
    .o_result_flags (resultFlags),
    .i_dbg_addr     (dbgAddr),
    .o_dbg_data     (dbgData)
  );

  // Stand-in combinational ALU
  assign aluData  = aluIn1 + aluIn2;
  assign aluFlags = 8'hA5;

  typedef struct {
    logic [7:0] data;
    logic [7:0] flags;
    int         wbCyc;
  } expT;

  expT expQ[$];
  expT popped;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit started = 1'b0;

  // Reference model state
  int         busy = 0;
  logic [7:0] mReg [8];
  logic [7:0] mIn1, mIn2, mResD, mResF;
  logic [2:0] mOp;
  logic [7:0] flIn1, flIn2, flSum;
  logic [2:0] flOp, flRd;
  logic       flNowb;
  logic [7:0] opA, opB;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: idle when busy==0; an accepted instruction occupies
  // DECODE, ALU_LAT EXEC cycles and one WB cycle, counted down in busy.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rstN) begin
      started <= 1'b1;
      busy    <= 0;
      for (int i = 0; i < 8; i++) mReg[i] <= 8'h00;
      mIn1  <= 8'h00;
      mIn2  <= 8'h00;
      mOp   <= 3'd0;
      mResD <= 8'h00;
      mResF <= 8'h00;
      expQ.delete();
    end else if (busy == 0) begin
      if (ldEn) begin
        mReg[ldAddr] <= ldData;
      end else if (instrValid) begin
        opA = mReg[instr[9:7]];
        opB = mReg[instr[6:4]];
        flIn1 <= opA;
        flIn2 <= opB;
        flSum <= opA + opB;
        flOp  <= instr[15:13];
        flRd  <= instr[12:10];
`ifdef CMP_NOWB_EN
        flNowb <= instr[3];
`else
        flNowb <= 1'b0;
`endif
        busy <= ALU_LAT + 2;
        expQ.push_back('{data: opA + opB, flags: 8'hA5, wbCyc: cyc + ALU_LAT + 2});
      end
    end else begin
      busy <= busy - 1;
      if (busy == ALU_LAT + 2) begin
        mIn1 <= flIn1;
        mIn2 <= flIn2;
        mOp  <= flOp;
      end
      if (busy == 2) begin
        mResD <= flSum;
        mResF <= 8'hA5;
      end
      if (busy == 1 && !flNowb) begin
        mReg[flRd] <= flSum;
      end
    end
  end

  // Monitor: compare every output against the model and pop the scoreboard on each result
  always @(negedge clk) begin
    if (started) begin
      checkOutput("instr_ready", instrReady, (busy == 0) && !ldEn);
      checkOutput("alu_in1", aluIn1, mIn1);
      checkOutput("alu_in2", aluIn2, mIn2);
      checkOutput("alu_opcode", aluOpcode, mOp);
      checkOutput("result_valid", resultValid, busy == 1);
      checkOutput("result_data", resultData, mResD);
      checkOutput("result_flags", resultFlags, mResF);
      checkOutput("dbg_data", dbgData, mReg[dbgAddr]);
      if (resultValid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          popped = expQ.pop_front();
          checkOutput("sb_data", resultData, popped.data);
          checkOutput("sb_flags", resultFlags, popped.flags);
          checkOutput("sb_wb_cycle", cyc, popped.wbCyc);
        end
      end else if (expQ.size() > 0 && expQ[0].wbCyc < cyc) begin
        checkOutput("sb_result_timeout", 0, 1);
        void'(expQ.pop_front());
      end
    end
  end

  function automatic logic [15:0] mkInstr(input logic [2:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2,
                                          input logic nowb);
    return {op, rd, rs1, rs2, nowb, 3'b101};
  endfunction

  task automatic applyStimulus(input logic r, input logic ld, input logic [2:0] la,
                               input logic [7:0] ldat, input logic v,
                               input logic [15:0] ins, input logic [2:0] da);
    rstN       = r;
    ldEn       = ld;
    ldAddr     = la;
    ldData     = ldat;
    instrValid = v;
    instr      = ins;
    dbgAddr    = da;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n, input logic [2:0] da);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 8'h00, 0, 16'h0000, da);
  endtask

  initial begin
    rstN = 0; ldEn = 0; ldAddr = 0; ldData = 0; instrValid = 0; instr = 0; dbgAddr = 0;
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 0, 8'h00, 0, 16'h0000, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 16'h0000, 0);

    // Basic add: r1=4, r2=4, r3 <- r1 op r2
    applyStimulus(1, 1, 1, 8'h04, 0, 16'h0000, 3);
    applyStimulus(1, 1, 2, 8'h04, 0, 16'h0000, 3);
    applyStimulus(1, 0, 0, 8'h00, 1, mkInstr(3'd4, 3'd3, 3'd1, 3'd2, 1'b0), 3);
    idleCycles(ALU_LAT + 4, 3);

    // All three indices equal: operand read precedes writeback
    applyStimulus(1, 1, 5, 8'hFF, 0, 16'h0000, 5);
    applyStimulus(1, 0, 0, 8'h00, 1, mkInstr(3'd1, 3'd5, 3'd5, 3'd5, 1'b0), 5);
    idleCycles(ALU_LAT + 4, 5);

    // Preload has priority over a waiting instruction, then ld_en during EXEC is ignored
    applyStimulus(1, 1, 6, 8'h33, 1, mkInstr(3'd2, 3'd7, 3'd6, 3'd6, 1'b0), 6);
    applyStimulus(1, 1, 6, 8'h33, 1, mkInstr(3'd2, 3'd7, 3'd6, 3'd6, 1'b0), 6);
    applyStimulus(1, 0, 0, 8'h00, 1, mkInstr(3'd2, 3'd7, 3'd6, 3'd6, 1'b0), 7);
    idleCycles(1, 0);
    applyStimulus(1, 1, 0, 8'h77, 0, 16'h0000, 0);
    idleCycles(ALU_LAT + 4, 7);

    // Reset while in EXEC abandons the instruction
    applyStimulus(1, 0, 0, 8'h00, 1, mkInstr(3'd3, 3'd4, 3'd6, 3'd7, 1'b0), 4);
    idleCycles(1, 4);
    applyStimulus(0, 0, 0, 8'h00, 0, 16'h0000, 4);
    idleCycles(ALU_LAT + 4, 4);

    // Compare-style instruction on r6 holding 33
    applyStimulus(1, 1, 6, 8'h33, 0, 16'h0000, 6);
    applyStimulus(1, 1, 1, 8'h10, 0, 16'h0000, 6);
    applyStimulus(1, 0, 0, 8'h00, 1, mkInstr(3'd5, 3'd6, 3'd1, 3'd6, 1'b1), 6);
    idleCycles(ALU_LAT + 4, 6);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 79) != 0),
                    ($urandom_range(0, 3) == 0),
                    3'($urandom_range(0, 7)),
                    8'($urandom),
                    ($urandom_range(0, 1) == 1),
                    16'($urandom),
                    3'($urandom_range(0, 7)));
    end
    idleCycles(ALU_LAT + 6, 0);
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Issue/writeback sequencer on the driving side of the 8-bit ALU (in1/in2/opcode -> data_out/flag_out). It accepts instruction words over a valid/ready handshake and reads two operands from an internal register file. It drives the ALU, waits a fixed settle time, then writes the result back and reports result and flags. It sits between instruction fetch and the combinational ALU in the multi-cycle datapath.

Parameters:
DATA_W, 8, operand/result width; must match ALU in1/in2/data_out.
NUM_REGS, 8, register file depth; 3-bit register indices.
ALU_LAT, 1, cycles the ALU inputs are held before capture; legal range 1..15.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
instr_valid  in  1  instruction present
instr_ready  out  1  controller can accept an instruction
instr  in  16  [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [3] nowb (optional feature), [2:0] reserved
ld_en  in  1  register preload strobe
ld_addr  in  3  preload register index
ld_data  in  DATA_W  preload value
alu_in1  out  DATA_W  to ALU in1
alu_in2  out  DATA_W  to ALU in2
alu_opcode  out  3  to ALU opcode
alu_data  in  DATA_W  from ALU data_out
alu_flags  in  8  from ALU flag_out
result_valid  out  1  one-cycle pulse at writeback
result_data  out  DATA_W  captured ALU result
result_flags  out  8  captured ALU flags
dbg_addr  in  3  debug register read index
dbg_data  out  DATA_W  combinational read of regfile[dbg_addr]

Behaviour:
- Reset (clk edge with rst_n=0): state=IDLE; all registers, alu_in1/alu_in2/alu_opcode, result_data, and result_flags = 0; result_valid=0. An in-flight instruction is abandoned without a regfile write.
- FSM: IDLE -> DECODE -> EXEC -> WB -> IDLE.
- instr_ready = (state==IDLE) && !ld_en. Preload has priority: ld_en in IDLE writes regfile[ld_addr]=ld_data at that edge. ld_en outside IDLE is ignored.
- Handshake at edge T (instr_valid && instr_ready): latch instr, go to DECODE. instr may change after acceptance.
- DECODE (T+1): register alu_in1=reg[rs1], alu_in2=reg[rs2], alu_opcode=opcode. Go to EXEC and load the wait counter with ALU_LAT.
- EXEC: hold ALU inputs stable. Decrement the counter each cycle. At count 1, capture alu_data and alu_flags into result_data and result_flags, then go to WB.
- WB: reg[rd]=result_data at the exiting edge; result_valid=1 for exactly this cycle; go to IDLE.
- With ALU_LAT=1, result_valid is high in cycle T+3 and instr_ready is high again in T+4.
- Outputs alu_* and result_* hold their last values between instructions.
- rs1==rs2 is legal. rd equal to rs1 or rs2 is legal, because operands are read in DECODE before WB.
- dbg_data reading rd during WB returns the old value; the new value is visible from the next cycle.
- instr[2:0] is ignored. No arithmetic is done in this block; widths pass through unchanged.

Optional Feature:
CMP_NOWB_EN. When defined, instr[3]=1 suppresses the regfile write in WB. result_valid, result_data, and result_flags still update, so the instruction acts as a compare/test. When undefined, instr[3] is ignored and every instruction writes rd.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W and FLAG_W (8);
  - opcode width (3);
  - the instruction field bit positions as localparams;
  - the state enumeration (IDLE, DECODE, EXEC, WB).
- One natural sub-module, alu_regfile. It has NUM_REGS x DATA_W storage, one synchronous write port (muxed preload/WB) and three combinational read ports (rs1, rs2, dbg). It resets to zero.

Test Plan:
1. Bench ALU model: data=in1+in2, flags=8'hA5. Preload r1=8'h04, r2=8'h04. Issue op=4, rd=3, rs1=1, rs2=2 at T -> alu_opcode=4 and alu_in1/in2=4 from T+1; result_valid only in T+3 with result_data=8'h08, result_flags=8'hA5; dbg r3=8'h08 from T+4.
2. ALU_LAT=3, same instruction -> result_valid at T+5. alu_in1/in2/opcode stay stable through all EXEC cycles; instr_ready stays low from T+1 to T+5.
3. r5=8'hFF, op with rd=5, rs1=5, rs2=5 (model in1+in2) -> r5=8'hFE after WB; the operand read pre-WB value FF.
4. Hold ld_en=1 with instr_valid=1 in IDLE -> instr_ready=0 and the preload completes. Drop ld_en -> the instruction is accepted next cycle. ld_en pulsed during EXEC -> regfile unchanged.
5. Assert rst_n=0 in the EXEC cycle -> next cycle all outputs are 0, result_valid never pulses, and rd is not written.
6. CMP_NOWB_EN defined, instr[3]=1, rd=6 holding 8'h33 -> result_valid pulses with the ALU result and r6 stays 8'h33. Macro undefined -> r6 is overwritten.
